// File: rtl/instr_pack.sv
// instr_pack: shared opcode and FSM state types for the iterative ALU.
package instr_pack;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } alu_state_t;

    typedef enum logic [4:0] {
        AMP  = 5'd0,
        LOR  = 5'd1,
        FLP  = 5'd2,
        EOR  = 5'd3,
        ROL  = 5'd4,
        ROR  = 5'd5,
        RSC  = 5'd6,
        LSC  = 5'd7,
        ADD  = 5'd8,
        SUB  = 5'd9,
        EQL8 = 5'd10,
        EQL5 = 5'd11,
        REVx = 5'd12,
        REVy = 5'd13,
        PARx = 5'd14,
        PARy = 5'd15,
        MULL = 5'd16,
        MULH = 5'd17
    } math;

    function automatic logic is_rot(input math op);
        return (op == ROL) || (op == ROR);
    endfunction

    function automatic logic is_mul(input math op);
        return (op == MULL) || (op == MULH);
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// ripple_adder: plain carry-ripple adder shared by add, subtract and multiply.
module ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    logic cc;

    // ripple the carry bit by bit from ci to co
    always_comb begin
        s  = '0;
        cc = ci;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ cc;
            cc   = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
        end
        co = cc;
    end

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: multi-cycle ALU with iterative rotates and shift-add multiply.
module iterative_alu
    import instr_pack::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  math              math_op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] m,
    input  logic             alu_rs,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] s_out,
    output logic             carry,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] TOP_MASK = ~{{(WIDTH-3){1'b0}}, 3'b111};

    alu_state_t       state, state_nx;
    math              op_r;
    logic             rs_r;
    logic [WIDTH-1:0] xr, yr, mr;
    logic [WIDTH-1:0] acc, lo, acc_nx, lo_nx;
    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             add_ci, add_co;
    logic [WIDTH-1:0] rev_x, rev_y, res;
    logic             res_c;
    logic [CW-1:0]    cnt, ld_cnt, amt;
    logic             accept, last, rot_zero;

    assign accept   = (state == IDLE) && start;
    assign last     = (cnt == CW'(1));
    assign amt      = CW'(y[SHW-1:0]);
    assign rot_zero = (yr[SHW-1:0] == '0);

    // RUN length: WIDTH steps for multiply, the rotate amount (min 1), else 1
    assign ld_cnt = is_mul(math_op) ? CW'(WIDTH)
                  : (is_rot(math_op) && amt != '0) ? amt
                  : CW'(1);

    // adder operands: multiply accumulates into the high half, SUB adds ~y + 1
    assign add_a  = is_mul(op_r) ? acc : xr;
    assign add_b  = is_mul(op_r) ? (lo[0] ? xr : '0) : (op_r == SUB ? ~yr : yr);
    assign add_ci = (op_r == SUB);

    ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign rev_x[i] = xr[WIDTH-1-i];
        assign rev_y[i] = yr[WIDTH-1-i];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next-state: accept in IDLE, leave RUN on the last iteration
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // one iteration step: shift-add for multiply, one-bit rotate otherwise
    always_comb begin
        acc_nx = acc;
        lo_nx  = lo;
        if (is_mul(op_r)) begin
            acc_nx = {add_co, add_s[WIDTH-1:1]};
            lo_nx  = {add_s[0], lo[WIDTH-1:1]};
        end else if (is_rot(op_r) && !rot_zero) begin
            acc_nx = (op_r == ROL) ? {acc[WIDTH-2:0], acc[WIDTH-1]} : {acc[0], acc[WIDTH-1:1]};
        end
    end

    // final result and carry, valid on the last RUN cycle
    always_comb begin
        res   = '0;
        res_c = 1'b0;
        case (op_r)
            AMP:  res = xr & yr;
            LOR:  res = xr | yr;
            FLP:  res = ~xr;
            EOR:  res = xr ^ yr;
            ROL:  res = acc_nx;
            ROR:  res = acc_nx;
            RSC: begin
                res   = {yr[0], xr[WIDTH-1:1]};
                res_c = xr[0];
            end
            LSC: begin
                res   = {xr[WIDTH-2:0], yr[WIDTH-1]};
                res_c = xr[WIDTH-1];
            end
            ADD, SUB: begin
                res   = add_s;
                res_c = add_co;
            end
            EQL8: res = {{(WIDTH-1){1'b0}}, xr == yr};
            EQL5: res = {{(WIDTH-1){1'b0}}, ((xr ^ mr) & TOP_MASK) == '0};
            REVx: res = rev_x;
            REVy: res = rev_y;
            PARx: res = {{(WIDTH-1){1'b0}}, ^xr};
            PARy: res = {{(WIDTH-1){1'b0}}, ^yr};
            MULL: res = lo_nx;
            MULH: begin
                res   = acc_nx;
                res_c = (acc_nx != '0);
            end
            default: res = '0;
        endcase
    end

    // operand capture on accept, iteration state advance while running
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr   <= '0;
            yr   <= '0;
            mr   <= '0;
            op_r <= AMP;
            rs_r <= 1'b0;
            cnt  <= '0;
            acc  <= '0;
            lo   <= '0;
        end else if (accept) begin
            xr   <= x;
            yr   <= y;
            mr   <= m;
            op_r <= math_op;
            rs_r <= alu_rs;
            cnt  <= ld_cnt;
            acc  <= is_rot(math_op) ? x : '0;
            lo   <= y;
        end else if (state == RUN) begin
            cnt  <= cnt - CW'(1);
            acc  <= acc_nx;
            lo   <= lo_nx;
        end
    end

    // result registers and flags update only on the RUN->DONE edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            s_out <= WIDTH'(1);
            carry <= 1'b0;
            zero  <= 1'b0;
        end else if (state == RUN && last) begin
            if (rs_r) s_out <= res;
            else      r_out <= res;
            carry <= res_c;
            zero  <= (res == '0);
        end
    end

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed checks of the iterative ALU at WIDTH 8 and 16.
module tb_iterative_alu;
    import instr_pack::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    math         op8 = AMP, op16 = AMP;
    logic [7:0]  x8 = '0, y8 = '0, m8 = '0;
    logic [15:0] x16 = '0, y16 = '0, m16 = '0;
    logic        rs8 = 1'b0, rs16 = 1'b0;
    logic        busy8, done8, carry8, zero8;
    logic        busy16, done16, carry16, zero16;
    logic [7:0]  r8, s8;
    logic [15:0] r16, s16;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        math        op;
        logic [7:0] a, b, c, e;
        logic       ec;
        int         ecyc;
    } vec_t;

    iterative_alu #(.WIDTH(8)) u_alu8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .math_op(op8),
        .x(x8), .y(y8), .m(m8), .alu_rs(rs8),
        .busy(busy8), .done(done8), .r_out(r8), .s_out(s8),
        .carry(carry8), .zero(zero8)
    );

    iterative_alu #(.WIDTH(16)) u_alu16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .math_op(op16),
        .x(x16), .y(y16), .m(m16), .alu_rs(rs16),
        .busy(busy16), .done(done16), .r_out(r16), .s_out(s16),
        .carry(carry16), .zero(zero16)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // issue one op on the 8-bit ALU; cyc is the cycle done appeared (-1 on timeout), returns in IDLE
    task automatic run_op(input math op, input logic [7:0] a, b, c, input logic rs, output int cyc);
        op8 = op; x8 = a; y8 = b; m8 = c; rs8 = rs; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        cyc = 1;
        while (!done8 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done8) cyc = -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (r8 !== 8'h00) begin n_fail++; $display("FAIL reset_r_out: got %h expected 00", r8); end
        n_checks++; if (s8 !== 8'h01) begin n_fail++; $display("FAIL reset_s_out: got %h expected 01", s8); end
        n_checks++; if ({busy8, done8, carry8, zero8} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy8, done8, carry8, zero8}); end
        n_checks++; if (s16 !== 16'h0001) begin n_fail++; $display("FAIL reset_s_out16: got %h expected 0001", s16); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add;
        int cyc;
        run_op(ADD, 8'hF0, 8'h20, 8'h00, 1'b0, cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL add_latency: got %0d expected 2", cyc); end
        n_checks++; if (r8 !== 8'h10) begin n_fail++; $display("FAIL add_r_out: got %h expected 10", r8); end
        n_checks++; if (carry8 !== 1'b1 || zero8 !== 1'b0) begin n_fail++; $display("FAIL add_flags: got c=%b z=%b expected c=1 z=0", carry8, zero8); end
        n_checks++; if (s8 !== 8'h01) begin n_fail++; $display("FAIL add_s_hold: got %h expected 01", s8); end
        n_checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL add_idle: got busy=%b done=%b expected 0 0", busy8, done8); end
    endtask

    task automatic test_sub;
        int cyc;
        run_op(SUB, 8'h05, 8'h05, 8'h00, 1'b1, cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL sub_latency: got %0d expected 2", cyc); end
        n_checks++; if (s8 !== 8'h00) begin n_fail++; $display("FAIL sub_s_out: got %h expected 00", s8); end
        n_checks++; if (carry8 !== 1'b1 || zero8 !== 1'b1) begin n_fail++; $display("FAIL sub_flags: got c=%b z=%b expected c=1 z=1", carry8, zero8); end
        n_checks++; if (r8 !== 8'h10) begin n_fail++; $display("FAIL sub_r_hold: got %h expected 10", r8); end
    endtask

    task automatic test_ops;
        vec_t v[14];
        int   cyc;
        v[0]  = '{AMP,          8'hCC, 8'hAA, 8'h00, 8'h88, 1'b0, 2};
        v[1]  = '{EOR,          8'hCC, 8'hAA, 8'h00, 8'h66, 1'b0, 2};
        v[2]  = '{FLP,          8'h0F, 8'h00, 8'h00, 8'hF0, 1'b0, 2};
        v[3]  = '{RSC,          8'h03, 8'h01, 8'h00, 8'h81, 1'b1, 2};
        v[4]  = '{LSC,          8'h81, 8'h80, 8'h00, 8'h03, 1'b1, 2};
        v[5]  = '{EQL5,         8'hA9, 8'h00, 8'hAF, 8'h01, 1'b0, 2};
        v[6]  = '{EQL8,         8'h12, 8'h13, 8'h00, 8'h00, 1'b0, 2};
        v[7]  = '{REVx,         8'h01, 8'h00, 8'h00, 8'h80, 1'b0, 2};
        v[8]  = '{PARy,         8'h00, 8'h07, 8'h00, 8'h01, 1'b0, 2};
        v[9]  = '{ROL,          8'h5A, 8'h08, 8'h00, 8'h5A, 1'b0, 2};
        v[10] = '{ROL,          8'h81, 8'h01, 8'h00, 8'h03, 1'b0, 2};
        v[11] = '{math'(5'd25), 8'h25, 8'h13, 8'h00, 8'h00, 1'b0, 2};
        v[12] = '{ADD,          8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 2};
        v[13] = '{SUB,          8'h03, 8'h05, 8'h00, 8'hFE, 1'b0, 2};
        for (int i = 0; i < 14; i++) begin
            run_op(v[i].op, v[i].a, v[i].b, v[i].c, 1'b0, cyc);
            n_checks++; if (r8 !== v[i].e) begin n_fail++; $display("FAIL op%0d_result: got %h expected %h", i, r8, v[i].e); end
            n_checks++; if (carry8 !== v[i].ec) begin n_fail++; $display("FAIL op%0d_carry: got %b expected %b", i, carry8, v[i].ec); end
            n_checks++; if (zero8 !== (v[i].e == 8'h00)) begin n_fail++; $display("FAIL op%0d_zero: got %b expected %b", i, zero8, v[i].e == 8'h00); end
            n_checks++; if (cyc !== v[i].ecyc) begin n_fail++; $display("FAIL op%0d_latency: got %0d expected %0d", i, cyc, v[i].ecyc); end
        end
    endtask

    task automatic test_ror_busy;
        int busy_n = 0;
        int done_at = -1;
        int pulses = 0;
        op8 = ROR; x8 = 8'h81; y8 = 8'h03; rs8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (busy8) busy_n++;
            if (done8) begin done_at = c; pulses++; end
            if (c == 2) begin start8 = 1'b1; op8 = ADD; x8 = 8'h00; y8 = 8'h00; end
            if (c == 3) start8 = 1'b0;
            @(posedge clk); #1;
        end
        n_checks++; if (busy_n !== 4) begin n_fail++; $display("FAIL ror_busy_cycles: got %0d expected 4", busy_n); end
        n_checks++; if (done_at !== 4) begin n_fail++; $display("FAIL ror_done_cycle: got %0d expected 4", done_at); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ror_done_pulses: got %0d expected 1", pulses); end
        n_checks++; if (r8 !== 8'h30) begin n_fail++; $display("FAIL ror_result: got %h expected 30", r8); end
        n_checks++; if (carry8 !== 1'b0 || zero8 !== 1'b0) begin n_fail++; $display("FAIL ror_flags: got c=%b z=%b expected c=0 z=0", carry8, zero8); end
    endtask

    task automatic test_mul;
        int cyc;
        run_op(MULH, 8'hFF, 8'hFF, 8'h00, 1'b0, cyc);
        n_checks++; if (cyc !== 9) begin n_fail++; $display("FAIL mulh_latency: got %0d expected 9", cyc); end
        n_checks++; if (r8 !== 8'hFE) begin n_fail++; $display("FAIL mulh_result: got %h expected FE", r8); end
        n_checks++; if (carry8 !== 1'b1) begin n_fail++; $display("FAIL mulh_carry: got %b expected 1", carry8); end
        run_op(MULL, 8'hFF, 8'hFF, 8'h00, 1'b1, cyc);
        n_checks++; if (s8 !== 8'h01) begin n_fail++; $display("FAIL mull_result: got %h expected 01", s8); end
        n_checks++; if (carry8 !== 1'b0 || cyc !== 9) begin n_fail++; $display("FAIL mull_carry_latency: got c=%b cyc=%0d expected c=0 cyc=9", carry8, cyc); end
        n_checks++; if (r8 !== 8'hFE) begin n_fail++; $display("FAIL mull_r_hold: got %h expected FE", r8); end
        run_op(MULL, 8'h0D, 8'h0B, 8'h00, 1'b0, cyc);
        n_checks++; if (r8 !== 8'h8F) begin n_fail++; $display("FAIL mull_small: got %h expected 8F", r8); end
        run_op(MULH, 8'h0D, 8'h0B, 8'h00, 1'b1, cyc);
        n_checks++; if (s8 !== 8'h00 || carry8 !== 1'b0 || zero8 !== 1'b1) begin n_fail++; $display("FAIL mulh_small: got s=%h c=%b z=%b expected 00 0 1", s8, carry8, zero8); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        int pulses = 0;
        run_op(ADD, 8'hF0, 8'h20, 8'h00, 1'b1, cyc);
        op8 = MULL; x8 = 8'hFF; y8 = 8'hFF; rs8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: got busy=%b done=%b expected 0 0", busy8, done8); end
        n_checks++; if (r8 !== 8'h00 || s8 !== 8'h01) begin n_fail++; $display("FAIL midrst_regs: got r=%h s=%h expected 00 01", r8, s8); end
        n_checks++; if (carry8 !== 1'b0 || zero8 !== 1'b0) begin n_fail++; $display("FAIL midrst_flags: got c=%b z=%b expected 0 0", carry8, zero8); end
        op8 = ADD; x8 = 8'h01; y8 = 8'h01; rs8 = 1'b0; start8 = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (done8 || busy8) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_start_ignored: got %0d active cycles expected 0", pulses); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL first_edge_accept: got busy=%b expected 1", busy8); end
        cyc = 1;
        while (!done8 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (cyc !== 2 || r8 !== 8'h02) begin n_fail++; $display("FAIL post_reset_add: got cyc=%0d r=%h expected 2 02", cyc, r8); end
        @(posedge clk); #1;
    endtask

    task automatic test_rol16;
        int cyc;
        op16 = ROL; x16 = 16'h8001; y16 = 16'd15; m16 = '0; rs16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        cyc = 1;
        while (!done16 && cyc < 100) begin @(posedge clk); #1; cyc++; end
        n_checks++; if (cyc !== 16) begin n_fail++; $display("FAIL rol16_latency: got %0d expected 16", cyc); end
        n_checks++; if (r16 !== 16'hC000) begin n_fail++; $display("FAIL rol16_result: got %h expected C000", r16); end
        n_checks++; if (carry16 !== 1'b0 || zero16 !== 1'b0 || s16 !== 16'h0001) begin n_fail++; $display("FAIL rol16_flags: got c=%b z=%b s=%h expected 0 0 0001", carry16, zero16, s16); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_ops;
        test_ror_busy;
        test_mul;
        test_reset_mid;
        test_rol16;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iterative_alu.md
ITERATIVE_ALU -- requirements
Module: iterative_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, datapath width in bits (legal 4..32).
REQ-002 SHALL have localparam SHW, default $clog2(WIDTH), rotate-amount field width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port math_op  input  math  operation; enum from instr_pack.
REQ-007 SHALL have port x  input  WIDTH  first operand.
REQ-008 SHALL have port y  input  WIDTH  second operand / rotate amount / carry-in source.
REQ-009 SHALL have port m  input  WIDTH  compare operand for EQL5.
REQ-010 SHALL have port alu_rs  input  1  destination: 0 r_out, 1 s_out.
REQ-011 SHALL have port busy  output  1  high while an op is in flight.
REQ-012 SHALL have port done  output  1  one-cycle pulse when results and flags update.
REQ-013 SHALL have ports r_out, s_out  output  WIDTH  result registers.
REQ-014 SHALL have ports carry, zero  output  1  flags from the last completed op.

Function
REQ-015 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE when the iteration count expires, DONE->IDLE unconditionally.
REQ-016 SHALL latch x, y, m, math_op and alu_rs on the accepting edge; later input changes SHALL NOT affect the op.
REQ-017 SHALL ignore start outside IDLE, with no queuing.
REQ-018 SHALL hold busy high in RUN and DONE, and pulse done high for exactly the DONE cycle.
REQ-019 SHALL complete AMP, LOR, FLP, EOR, RSC, LSC, ADD, SUB, EQL8, EQL5, REVx, REVy, PARx and PARy with one RUN cycle, so done is asserted 2 cycles after the start edge.
REQ-020 SHALL give generalised semantics at WIDTH: RSC = {y[0],x[W-1:1]}; LSC = {x[W-2:0],y[W-1]}; EQL5 compares the top WIDTH-3 bits of x and m; EQL8, EQL5, PARx and PARy are zero-extended.
REQ-021 SHALL perform ROL/ROR iteratively, one bit position per RUN cycle, for y[SHW-1:0] cycles; an amount of 0 SHALL still take one RUN cycle and return x.
REQ-022 SHALL implement new ops MULL/MULH as unsigned shift-add multiplies over WIDTH RUN cycles; MULL writes the product low half, MULH the high half, to the alu_rs destination.
REQ-023 SHALL compute ADD as x+y with carry = carry-out, and SUB as x+~y+1 with carry = 1 when x>=y (no borrow); wrap-around is modulo 2^WIDTH.
REQ-024 SHALL set carry for RSC to x[0], for LSC to x[W-1], for MULH to (result!=0), and clear it for all other ops.
REQ-025 SHALL set zero = (result==0) for every op.
REQ-026 SHALL write only the selected destination register plus both flags, and only on the RUN->DONE edge; the other register SHALL hold.
REQ-027 SHALL treat an undefined math_op as result 0 completing in one cycle, giving zero=1 and carry=0.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-operation, go to IDLE with s_out=1, r_out=0, carry=0, zero=0, busy=0, done=0 and the iteration counter cleared.
REQ-029 SHALL ignore start while rst_n is low; the first op is accepted on the first rising edge with rst_n high.

Structure
REQ-030 SHALL add MULL and MULH to the math enum in instr_pack, keeping existing encodings; FSM state typedef alu_state_t SHALL also live in instr_pack.
REQ-031 SHALL instantiate one sub-module, ripple_adder (parameter WIDTH; inputs a, b, ci; outputs s, co), shared by ADD, SUB and the multiply accumulate step.

Verification
REQ-032 Bench SHALL check: WIDTH=8, ADD x=0xF0, y=0x20, alu_rs=0 -> done at cycle 2, r_out=0x10, carry=1, zero=0, s_out stays 1.
REQ-033 Bench SHALL check: SUB x=0x05, y=0x05, alu_rs=1 -> s_out=0x00, carry=1, zero=1.
REQ-034 Bench SHALL check: ROR x=0x81, y=3 -> busy for 4 cycles, result 0x30; start pulsed again while busy -> ignored.
REQ-035 Bench SHALL check: MULH x=0xFF, y=0xFF -> done after WIDTH+1 cycles, result 0xFE, carry=1; MULL with the same operands -> 0x01.
REQ-036 Bench SHALL check: rst_n dropped mid-MULL at RUN cycle 4 -> immediate IDLE, r_out=0, s_out=1, flags 0, no done pulse.
REQ-037 Bench SHALL check: WIDTH=16, ROL x=0x8001, y=15 -> result 0xC000, completing in 15 RUN cycles.
